hazard_sb_unit: RTL and testbench

- Next-generation pipeline hazard controller for the 5-stage RV32I core (F/D/E/M/W).
- Adds the following to EX-stage forwarding, load-use stall and branch flush:
  - a register scoreboard for a multi-cycle MUL/DIV unit (MDU);
  - whole-pipe freeze on data-memory wait;
  - correct x0 handling on both forwarding operands;
  - a saturating stall-cycle performance counter.
- Sits beside the pipeline registers and drives every stall, flush and forward-select line.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/reg_scoreboard.sv | 48 ++++
 rtl/hazard_sb_unit.sv | 136 +++++++++++++
 tb/tb_hazard_sb_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants for the RV32I hazard controller: forward selects and result-source codes.
// No logic, so no latency and no backpressure.
package hazard_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    localparam logic [1:0] RES_LOAD = 2'b01;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write bit per architectural register for the multi-cycle MDU; set wins over clear.
// Updates land on the next edge; reads bypass a same-cycle clear. Never stalls by itself.
module reg_scoreboard #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_addr,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_addr,
    input  logic [REG_ADDR_W-1:0] i_rd1_addr,
    input  logic [REG_ADDR_W-1:0] i_rd2_addr,
    input  logic [REG_ADDR_W-1:0] i_waw_addr,
    output logic                  o_rd1_busy,
    output logic                  o_rd2_busy,
    output logic                  o_waw_busy
);

    localparam int DEPTH = 2**REG_ADDR_W;

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_set_mask;
    logic [DEPTH-1:0] w_clr_mask;
    logic [DEPTH-1:0] w_eff;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en) w_set_mask[i_set_addr] = 1'b1;
        if (i_clr_en) w_clr_mask[i_clr_addr] = 1'b1;
        // x0 can never be pending, so it never blocks anything
        w_set_mask[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_pending <= '0;
        else      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end

    // The MDU writes the register file in the first half of writeback, so readers see it now
    assign w_eff = r_pending & ~w_clr_mask;

    assign o_rd1_busy = w_eff[i_rd1_addr];
    assign o_rd2_busy = w_eff[i_rd2_addr];
    assign o_waw_busy = w_eff[i_waw_addr];

endmodule

// File: rtl/hazard_sb_unit.sv
// Hazard controller for the 5-stage core: EX forwarding, load-use/MDU stalls, branch flush, memory-wait freeze.
// All controls are same-cycle combinational; scoreboard and StallCount update on the next edge.
module hazard_sb_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16,
    parameter int RESULT_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] Rs1D,
    input  logic [REG_ADDR_W-1:0] Rs2D,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  RegWriteD,
    input  logic [REG_ADDR_W-1:0] Rs1E,
    input  logic [REG_ADDR_W-1:0] Rs2E,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic                  RegWriteE,
    input  logic [RESULT_W-1:0]   ResultSrcE,
    input  logic                  LongOpE,
    input  logic                  PCSrcE,
    input  logic [REG_ADDR_W-1:0] RdM,
    input  logic                  RegWriteM,
    input  logic                  MemReadyM,
    input  logic [REG_ADDR_W-1:0] RdW,
    input  logic                  RegWriteW,
    input  logic                  LongDoneW,
    input  logic [REG_ADDR_W-1:0] LongRdW,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  StallE,
    output logic                  StallM,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic                  FlushW,
    output logic [CNT_W-1:0]      StallCount
);

    logic            w_rs1_busy;
    logic            w_rs2_busy;
    logic            w_rd_busy;
    logic            w_lw;
    logic            w_sb;
    logic            w_mw;
    fwd_sel_t        w_fwd_a;
    fwd_sel_t        w_fwd_b;
    logic            w_stall_f;
    logic            w_stall_d;
    logic            w_stall_e;
    logic            w_stall_m;
    logic            w_flush_d;
    logic            w_flush_e;
    logic            w_flush_w;
    logic [CNT_W-1:0] r_stall_cnt;

    reg_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (LongOpE & MemReadyM),
        .i_set_addr (RdE),
        .i_clr_en   (LongDoneW),
        .i_clr_addr (LongRdW),
        .i_rd1_addr (Rs1D),
        .i_rd2_addr (Rs2D),
        .i_waw_addr (RdD),
        .o_rd1_busy (w_rs1_busy),
        .o_rd2_busy (w_rs2_busy),
        .o_waw_busy (w_rd_busy)
    );

    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (rst) begin
            if (RegWriteM && (RdM != '0) && (Rs1E == RdM))      w_fwd_a = FWD_MEM;
            else if (RegWriteW && (RdW != '0) && (Rs1E == RdW)) w_fwd_a = FWD_WB;
            if (RegWriteM && (RdM != '0) && (Rs2E == RdM))      w_fwd_b = FWD_MEM;
            else if (RegWriteW && (RdW != '0) && (Rs2E == RdW)) w_fwd_b = FWD_WB;
        end
    end

    assign w_lw = (ResultSrcE == RESULT_W'(RES_LOAD)) && RegWriteE && (RdE != '0)
                  && ((Rs1D == RdE) || (Rs2D == RdE));
    // The RdD term keeps a younger writer from landing before the MDU result (WAW)
    assign w_sb = w_rs1_busy || w_rs2_busy || (RegWriteD && w_rd_busy);
    assign w_mw = !MemReadyM;

    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_flush_w = 1'b0;
        if (!rst) begin
            w_stall_f = 1'b0;
        end else if (w_mw) begin
            // Freeze everything; a taken branch stays in E and is re-evaluated afterwards
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_flush_w = 1'b1;
        end else if (PCSrcE) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_lw || w_sb) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      r_stall_cnt <= '0;
        else if (w_stall_f && (r_stall_cnt != '1))     r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign ForwardAE  = w_fwd_a;
    assign ForwardBE  = w_fwd_b;
    assign StallF     = w_stall_f;
    assign StallD     = w_stall_d;
    assign StallE     = w_stall_e;
    assign StallM     = w_stall_m;
    assign FlushD     = w_flush_d;
    assign FlushE     = w_flush_e;
    assign FlushW     = w_flush_w;
    assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_hazard_sb_unit.sv
// Scoreboard bench for hazard_sb_unit: directed scenarios then random traffic against a rule-level model.
module tb_hazard_sb_unit;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic       rst;
        logic [4:0] rs1d, rs2d, rdd;
        logic       rwd;
        logic [4:0] rs1e, rs2e, rde;
        logic       rwe;
        logic [1:0] rse;
        logic       longe, pcs;
        logic [4:0] rdm;
        logic       rwm, mrdy;
        logic [4:0] rdw;
        logic       rww, ldone;
        logic [4:0] lrd;
    } in_t;

    typedef struct {
        logic [1:0] fa, fb;
        logic [6:0] ctl;   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
        logic [3:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongRdW;
    logic RegWriteD, RegWriteE, LongOpE, PCSrcE, RegWriteM, MemReadyM, RegWriteW, LongDoneW;
    logic [1:0] ResultSrcE;
    logic [1:0] ForwardAE, ForwardBE;
    logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [CNT_W-1:0] StallCount;

    int n_cmp = 0;
    int n_err = 0;
    exp_t expq[$];
    in_t  cur;
    bit   pend [0:31];
    int   cnt = 0;

    always #5 clk = ~clk;

    hazard_sb_unit #(.REG_ADDR_W(5), .CNT_W(CNT_W), .RESULT_W(2)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .RegWriteD(RegWriteD),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
        .ResultSrcE(ResultSrcE), .LongOpE(LongOpE), .PCSrcE(PCSrcE),
        .RdM(RdM), .RegWriteM(RegWriteM), .MemReadyM(MemReadyM),
        .RdW(RdW), .RegWriteW(RegWriteW), .LongDoneW(LongDoneW), .LongRdW(LongRdW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .StallCount(StallCount)
    );

    function automatic in_t idle();
        in_t s;
        s = '{default: '0};
        s.rst  = 1'b1;
        s.mrdy = 1'b1;
        return s;
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] rs, input in_t s);
        if (s.rwm && s.rdm != 0 && rs == s.rdm) return 2'b10;
        if (s.rww && s.rdw != 0 && rs == s.rdw) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit busy(input logic [4:0] r, input in_t s);
        return pend[r] && !(s.ldone && s.lrd == r);
    endfunction

    function automatic exp_t eval(input in_t s);
        exp_t e;
        bit lw, sb;
        e.fa = 2'b00; e.fb = 2'b00; e.ctl = 7'b0; e.cnt = 4'(cnt);
        if (!s.rst) return e;
        e.fa = fwd(s.rs1e, s);
        e.fb = fwd(s.rs2e, s);
        lw = s.rse == 2'b01 && s.rwe && s.rde != 0 && (s.rs1d == s.rde || s.rs2d == s.rde);
        sb = busy(s.rs1d, s) || busy(s.rs2d, s) || (s.rwd && busy(s.rdd, s));
        if (!s.mrdy)       e.ctl = 7'b1111001;
        else if (s.pcs)    e.ctl = 7'b0000110;
        else if (lw || sb) e.ctl = 7'b1100010;
        return e;
    endfunction

    // Effect of the clock edge just taken, using the inputs that were held across it
    task automatic model_edge();
        exp_t e;
        bit nxt [0:31];
        if (!cur.rst) begin
            foreach (pend[r]) pend[r] = 1'b0;
            cnt = 0;
            return;
        end
        e = eval(cur);
        foreach (pend[r]) begin
            if (cur.longe && cur.rde == r && r != 0 && cur.mrdy) nxt[r] = 1'b1;
            else if (cur.ldone && cur.lrd == r)                   nxt[r] = 1'b0;
            else                                                  nxt[r] = pend[r];
        end
        pend = nxt;
        if (e.ctl[6] && cnt < CMAX) cnt++;
    endtask

    task automatic drive(input in_t s);
        rst = s.rst; Rs1D = s.rs1d; Rs2D = s.rs2d; RdD = s.rdd; RegWriteD = s.rwd;
        Rs1E = s.rs1e; Rs2E = s.rs2e; RdE = s.rde; RegWriteE = s.rwe; ResultSrcE = s.rse;
        LongOpE = s.longe; PCSrcE = s.pcs; RdM = s.rdm; RegWriteM = s.rwm; MemReadyM = s.mrdy;
        RdW = s.rdw; RegWriteW = s.rww; LongDoneW = s.ldone; LongRdW = s.lrd;
    endtask

    task automatic step(input in_t s);
        @(posedge clk);
        #1;
        model_edge();
        cur = s;
        drive(s);
        if (!s.rst) begin
            foreach (pend[r]) pend[r] = 1'b0;
            cnt = 0;
        end
        expq.push_back(eval(s));
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("ForwardAE", {6'b0, ForwardAE}, {6'b0, e.fa});
                chk("ForwardBE", {6'b0, ForwardBE}, {6'b0, e.fb});
                chk("stall_flush", {1'b0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW},
                    {1'b0, e.ctl});
                chk("StallCount", {4'b0, StallCount}, {4'b0, e.cnt});
            end
        end
    end

    initial begin : stimulus
        in_t s;
        cur = idle();
        cur.rst = 1'b0;
        drive(cur);

        // Reset held, then released
        repeat (3) step(cur);
        step(idle());

        // Forwarding: MEM beats WB, x0 never forwards, WB-only path
        s = idle(); s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1; s.rs1e = 5; s.rs2e = 5; step(s);
        s = idle(); s.rdm = 0; s.rwm = 1; s.rdw = 0; s.rww = 1; s.rs2e = 0; step(s);
        s = idle(); s.rdw = 3; s.rww = 1; s.rs1e = 3; s.rs2e = 4; s.rdm = 4; s.rwm = 0; step(s);

        // Load-use: one stall, then the load sits in M and forwards
        s = idle(); s.rse = 2'b01; s.rwe = 1; s.rde = 7; s.rs2d = 7; step(s);
        s = idle(); s.rdm = 7; s.rwm = 1; s.rs2e = 7; step(s);

        // MDU scoreboard on x9: issue, wait, dependent stalls until the same-cycle release
        s = idle(); s.longe = 1; s.rde = 9; step(s);
        repeat (3) step(idle());
        s = idle(); s.rs1d = 9; step(s); step(s);
        s.ldone = 1; s.lrd = 9; step(s);
        s = idle(); s.rs1d = 9; step(s);

        // Set and clear of x9 together: set wins
        s = idle(); s.longe = 1; s.rde = 9; step(s);
        s.ldone = 1; s.lrd = 9; step(s);
        s = idle(); s.rs1d = 9; step(s);
        s = idle(); s.rwd = 1; s.rdd = 9; step(s);
        s = idle(); s.ldone = 1; s.lrd = 9; step(s);

        // Memory wait with a taken branch in E
        s = idle(); s.mrdy = 0; s.pcs = 1; repeat (4) step(s);

        // Branch overrides a load-use hazard
        s = idle(); s.rse = 2'b01; s.rwe = 1; s.rde = 7; s.rs1d = 7; s.pcs = 1; step(s);

        // Counter saturation
        s = idle(); s.rse = 2'b01; s.rwe = 1; s.rde = 7; s.rs1d = 7; repeat (20) step(s);

        // Reset in the middle of an MDU stall
        s = idle(); s.longe = 1; s.rde = 9; step(s);
        s = idle(); s.rs1d = 9; step(s);
        s.rst = 0; step(s);
        s.rst = 1; step(s); step(s);

        // Random traffic on a small register window to provoke collisions
        for (int i = 0; i < 500; i++) begin
            s.rst   = ($urandom_range(0, 99) != 0);
            s.rs1d  = 5'($urandom_range(0, 7)); s.rs2d = 5'($urandom_range(0, 7));
            s.rdd   = 5'($urandom_range(0, 7)); s.rwd  = 1'($urandom_range(0, 1));
            s.rs1e  = 5'($urandom_range(0, 7)); s.rs2e = 5'($urandom_range(0, 7));
            s.rde   = 5'($urandom_range(0, 7)); s.rwe  = 1'($urandom_range(0, 1));
            s.rse   = 2'($urandom_range(0, 3));
            s.longe = ($urandom_range(0, 4) == 0);
            s.pcs   = ($urandom_range(0, 7) == 0);
            s.rdm   = 5'($urandom_range(0, 7)); s.rwm  = 1'($urandom_range(0, 1));
            s.mrdy  = ($urandom_range(0, 6) != 0);
            s.rdw   = 5'($urandom_range(0, 7)); s.rww  = 1'($urandom_range(0, 1));
            s.ldone = ($urandom_range(0, 3) == 0);
            s.lrd   = 5'($urandom_range(0, 7));
            step(s);
        end

        @(negedge clk);
        #1;
        n_cmp++;
        if (expq.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
